// File: rtl/cpu_io_pkg.sv
// Shared types and widths for the CPU switch front-end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_io_pkg;

    localparam int SW_W   = 8;
    localparam int OP_W   = 4;
    localparam int DATA_W = SW_W + OP_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS_WAIT,
        ST_FIRE,
        ST_HELD,
        ST_RELEASE_WAIT
    } btn_state_e;

endpackage

// File: rtl/cpu_switch_conditioner_if.sv
// Board-pin side and CPU side signals of the switch conditioner.
// Latency: n/a (wiring only).
// Backpressure: none; the CPU consumes enable unconditionally.
interface cpu_switch_conditioner_if;
    import cpu_io_pkg::*;

    logic [SW_W-1:0] sw_raw;
    logic [OP_W-1:0] op_raw;
    logic            btn_go_raw;
    logic [SW_W-1:0] sw_out;
    logic [OP_W-1:0] op_out;
    logic            enable;
    logic            busy;

    // Drives the pins and watches the CPU-side outputs.
    modport master (
        output sw_raw, op_raw, btn_go_raw,
        input  sw_out, op_out, enable, busy
    );

    // The conditioner itself.
    modport slave (
        input  sw_raw, op_raw, btn_go_raw,
        output sw_out, op_out, enable, busy
    );

endinterface

// File: rtl/debounce_vec.sv
// Two-flop synchroniser plus optional stable-level filter on a W-bit vector.
// Latency: 2 cycles (FILTER=0); 2 + DEBOUNCE_CYCLES + 1 cycles to move stable_o (FILTER=1).
// Backpressure: none; free-running on every cycle.
module debounce_vec #(
    parameter int W               = 1,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 20,
    parameter bit FILTER          = 1'b1
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [W-1:0] raw_i,
    output logic [W-1:0] stable_o
);

    // The counter must hold DEBOUNCE_CYCLES-1 without wrapping; the release
    // path of the button FSM also needs DEBOUNCE_CYCLES >= 2.
    if (((DEBOUNCE_CYCLES >> CNT_W) != 0) || (DEBOUNCE_CYCLES < 2)) begin : g_bad_params
        $error("debounce_vec: CNT_W too narrow for DEBOUNCE_CYCLES, or DEBOUNCE_CYCLES < 2");
    end

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Two-flop synchroniser for the asynchronous board inputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= raw_i;
            sync_q <= meta_q;
        end
    end

    if (FILTER) begin : g_filt
        localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

        logic [W-1:0]     prev_q;
        logic [W-1:0]     stable_q;
        logic [W-1:0]     stable_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;

        // Count cycles the synchronised vector sits unchanged at a new value;
        // any change restarts the run, matching the stable level clears it.
        always_comb begin
            stable_d = stable_q;
            cnt_d    = '0;
            if (sync_q == stable_q) begin
                cnt_d = '0;
            end else if (sync_q != prev_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                stable_d = sync_q;
                cnt_d    = '0;
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end

        // Filter state registers.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                prev_q   <= '0;
                stable_q <= '0;
                cnt_q    <= '0;
            end else begin
                prev_q   <= sync_q;
                stable_q <= stable_d;
                cnt_q    <= cnt_d;
            end
        end

        assign stable_o = stable_q;
    end else begin : g_pass
        assign stable_o = sync_q;
    end

endmodule

// File: rtl/cpu_switch_conditioner.sv
// Syncs/debounces switches and GO button; one enable per accepted press with a coherent snapshot.
// Latency: enable 2+DEBOUNCE_CYCLES+2 cycles after the GO rise; busy drops 2+DEBOUNCE_CYCLES after release.
// Backpressure: none; presses arriving while busy are absorbed by the FSM.
module cpu_switch_conditioner
    import cpu_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 20
) (
    input  logic                     clock,
    input  logic                     reset_n,
    cpu_switch_conditioner_if.slave  io
);

    localparam logic [CNT_W-1:0] PRESS_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    // The low sample that moves HELD to RELEASE_WAIT is the first of the
    // stable-low run, so the wait state itself counts one fewer cycle.
    localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

    logic [DATA_W-1:0] data_deb;
    logic              btn_sync;

    debounce_vec #(
        .W               (DATA_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W),
        .FILTER          (1'b1)
    ) u_data_deb (
        .clock    (clock),
        .reset_n  (reset_n),
        .raw_i    ({io.op_raw, io.sw_raw}),
        .stable_o (data_deb)
    );

    // Button is only synchronised here; its debounce lives in the FSM.
    debounce_vec #(
        .W               (1),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W),
        .FILTER          (1'b0)
    ) u_btn_sync (
        .clock    (clock),
        .reset_n  (reset_n),
        .raw_i    (io.btn_go_raw),
        .stable_o (btn_sync)
    );

    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fire;
    logic [1:0]       boot_q;
    logic             armed_q;
    logic [SW_W-1:0]  sw_q;
    logic [OP_W-1:0]  op_q;
    logic             en_q;

    // Next-state logic: press/release qualification with a shared saturating counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fire    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (btn_sync && armed_q) state_d = ST_PRESS_WAIT;
            end
            ST_PRESS_WAIT: begin
                if (!btn_sync) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == PRESS_LAST) begin
                    state_d = ST_FIRE;
                    cnt_d   = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FIRE: begin
                fire    = 1'b1;
                state_d = ST_HELD;
                cnt_d   = '0;
            end
            ST_HELD: begin
                cnt_d = '0;
                if (!btn_sync) state_d = ST_RELEASE_WAIT;
            end
            ST_RELEASE_WAIT: begin
                if (btn_sync) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == RELEASE_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state and counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A button still held through reset must not fire: arm only after a
    // genuine low is seen once the synchroniser has refilled.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            boot_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            boot_q  <= {boot_q[0], 1'b1};
            armed_q <= armed_q | (boot_q[1] & ~btn_sync);
        end
    end

    // Snapshot on FIRE only; enable follows one cycle later with data stable.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sw_q <= '0;
            op_q <= '0;
            en_q <= 1'b0;
        end else begin
            en_q <= fire;
            if (fire) begin
                sw_q <= data_deb[SW_W-1:0];
                op_q <= data_deb[DATA_W-1:SW_W];
            end
        end
    end

    assign io.sw_out = sw_q;
    assign io.op_out = op_q;
    assign io.enable = en_q;
    assign io.busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cpu_switch_conditioner.sv
module tb_cpu_switch_conditioner;

    logic clock;
    logic reset_n;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_en = 0;
    int   n_exp = 0;

    typedef struct {
        logic [7:0] sw;
        logic [3:0] op;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];

    cpu_switch_conditioner_if sif ();

    cpu_switch_conditioner #(
        .DEBOUNCE_CYCLES (16),
        .CNT_W           (20)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .io      (sif.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Expect an enable 2 sync + 16 debounce + FIRE + registered enable = 20 cycles after the rise.
    task automatic expect_press(input logic [7:0] sw, input logic [3:0] op);
        exp_t e;
        e.sw  = sw;
        e.op  = op;
        e.cyc = cyc + 20;
        sb_q.push_back(e);
        n_exp++;
    endtask

    // Scoreboard monitor: every enable cycle must match the oldest expected press.
    always @(negedge clock) begin
        if (reset_n && sif.enable === 1'b1) begin
            n_en++;
            if (sb_q.size() == 0) begin
                check("unexpected_enable", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("enable_cycle", cyc, e.cyc);
                check("sw_out_at_en", {24'd0, sif.sw_out}, {24'd0, e.sw});
                check("op_out_at_en", {28'd0, sif.op_out}, {28'd0, e.op});
            end
        end
    end

    initial begin
        int c;
        reset_n        = 1'b0;
        sif.sw_raw     = '0;
        sif.op_raw     = '0;
        sif.btn_go_raw = 1'b0;

        // Reset with random pin activity.
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            sif.sw_raw     = 8'($urandom);
            sif.op_raw     = 4'($urandom);
            sif.btn_go_raw = 1'($urandom);
        end
        tick(1);
        check("rst_sw_out", {24'd0, sif.sw_out}, 32'h00);
        check("rst_op_out", {28'd0, sif.op_out}, 32'h0);
        check("rst_enable", {31'd0, sif.enable}, 32'd0);
        check("rst_busy",   {31'd0, sif.busy},   32'd0);

        sif.btn_go_raw = 1'b0;
        sif.sw_raw     = 8'h1F;
        sif.op_raw     = 4'h1;
        reset_n        = 1'b1;
        tick(25);

        // Clean press: 40 high, then release; busy falls 18 cycles after release.
        expect_press(8'h1F, 4'h1);
        sif.btn_go_raw = 1'b1;
        tick(40);
        sif.btn_go_raw = 1'b0;
        tick(17);
        check("clean_busy_before_fall", {31'd0, sif.busy}, 32'd1);
        tick(1);
        check("clean_busy_after_fall", {31'd0, sif.busy}, 32'd0);
        check("clean_sw_hold", {24'd0, sif.sw_out}, 32'h1F);
        tick(5);

        // Glitch: 5-cycle pulse is rejected.
        sif.btn_go_raw = 1'b1;
        tick(5);
        check("glitch_busy_high", {31'd0, sif.busy}, 32'd1);
        sif.btn_go_raw = 1'b0;
        tick(10);
        check("glitch_busy_low", {31'd0, sif.busy}, 32'd0);
        check("glitch_sw_unchanged", {24'd0, sif.sw_out}, 32'h1F);

        // Bouncing release.
        sif.sw_raw = 8'h3C;
        sif.op_raw = 4'h5;
        tick(25);
        expect_press(8'h3C, 4'h5);
        sif.btn_go_raw = 1'b1;
        tick(30);
        for (int i = 0; i < 10; i++) begin
            sif.btn_go_raw = (i % 2 == 1);
            tick(3);
            check("bounce_busy", {31'd0, sif.busy}, 32'd1);
        end
        sif.btn_go_raw = 1'b0;
        tick(17);
        check("bounce_busy_before_fall", {31'd0, sif.busy}, 32'd1);
        tick(1);
        check("bounce_busy_after_fall", {31'd0, sif.busy}, 32'd0);
        tick(5);

        // Switch bounce across FIRE keeps the old debounced value.
        sif.sw_raw = 8'h0F;
        sif.op_raw = 4'h3;
        tick(25);
        expect_press(8'h0F, 4'h3);
        sif.btn_go_raw = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sif.sw_raw = (i % 2 == 0) ? 8'hF0 : 8'h0F;
            tick(4);
        end
        sif.btn_go_raw = 1'b0;
        sif.sw_raw     = 8'hF0;
        tick(40);
        check("swbounce_sw_first", {24'd0, sif.sw_out}, 32'h0F);
        expect_press(8'hF0, 4'h3);
        sif.btn_go_raw = 1'b1;
        tick(25);
        sif.btn_go_raw = 1'b0;
        tick(25);
        check("swbounce_sw_second", {24'd0, sif.sw_out}, 32'hF0);

        // Back-to-back presses with op change in the gap.
        sif.sw_raw = 8'h55;
        sif.op_raw = 4'h1;
        tick(25);
        expect_press(8'h55, 4'h1);
        sif.btn_go_raw = 1'b1;
        tick(25);
        sif.btn_go_raw = 1'b0;
        sif.op_raw     = 4'h2;
        tick(20);
        expect_press(8'h55, 4'h2);
        sif.btn_go_raw = 1'b1;
        tick(25);
        check("b2b_op_second", {28'd0, sif.op_out}, 32'h2);

        // Reset while HELD, button kept high afterwards.
        check("held_busy", {31'd0, sif.busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("midrst_sw_out", {24'd0, sif.sw_out}, 32'h00);
        check("midrst_op_out", {28'd0, sif.op_out}, 32'h0);
        check("midrst_busy",   {31'd0, sif.busy},   32'd0);
        check("midrst_enable", {31'd0, sif.enable}, 32'd0);
        tick(2);
        reset_n = 1'b1;
        tick(40);
        check("postrst_held_busy", {31'd0, sif.busy}, 32'd0);
        check("postrst_held_sw", {24'd0, sif.sw_out}, 32'h00);
        sif.btn_go_raw = 1'b0;
        tick(5);
        expect_press(8'h55, 4'h2);
        sif.btn_go_raw = 1'b1;
        tick(25);
        sif.btn_go_raw = 1'b0;
        tick(25);

        c = sb_q.size();
        check("sb_drained", c, 32'd0);
        check("enable_count", n_en, n_exp);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
